// File: rtl/op_dispatch_if.sv
// op_dispatch_if: request/response handshake plus GET/PUT/DEL sub-FSM strobes
//  master: requester and sub-FSM side (drives req, resp_ready, done/error)
//  slave : dispatcher side (drives req_ready, resp, busy, en/enter)
interface op_dispatch_if;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic       resp_valid, resp_ready;
  logic [1:0] resp_status;
  logic       busy;
  logic       get_en, put_en, del_en;
  logic       get_enter, put_enter, del_enter;
  logic       get_done, put_done, del_done;
  logic       get_error, put_error, del_error;
  modport master(
    output req_valid, req_op, resp_ready,
           get_done, put_done, del_done, get_error, put_error, del_error,
    input  req_ready, resp_valid, resp_status, busy,
           get_en, put_en, del_en, get_enter, put_enter, del_enter
  );
  modport slave(
    input  req_valid, req_op, resp_ready,
           get_done, put_done, del_done, get_error, put_error, del_error,
    output req_ready, resp_valid, resp_status, busy,
           get_en, put_en, del_en, get_enter, put_enter, del_enter
  );
endinterface

// File: rtl/op_dispatch_fsm.sv
// op_dispatch_fsm: accepts one cache op, runs the selected GET/PUT/DEL sub-FSM with a
//  watchdog, and returns a status word.
//  clk, rst_n (async active-low); bus.slave carries req_*/resp_*, busy, *_en/*_enter
//  outputs and *_done/*_error inputs. resp_status: 0=OK 1=ERROR 2=TIMEOUT 3=ILLEGAL.
module op_dispatch_fsm #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  op_dispatch_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;
  typedef enum logic [1:0] {ST_OK, ST_ERROR, ST_TIMEOUT, ST_ILLEGAL} status_e;
  state_e        state_q, state_d;
  status_e       status_q, status_d;
  logic [1:0]    op_q, op_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          run, enter, sel_done, sel_error;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= ST_OK;
      op_q     <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      op_q     <= op_d;
      wdog_q   <= wdog_d;
    end
  // wdog is cleared on accept and set to 1 in the enter cycle, so zero marks the enter cycle
  assign run       = state_q == RUN;
  assign enter     = run && wdog_q == '0;
  assign sel_done  = op_q == 2'd1 ? bus.get_done  : op_q == 2'd2 ? bus.put_done  : bus.del_done;
  assign sel_error = op_q == 2'd1 ? bus.get_error : op_q == 2'd2 ? bus.put_error : bus.del_error;
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    op_d     = op_q;
    wdog_d   = wdog_q;
    case (state_q)
      IDLE:
        if (bus.req_valid) begin
          if (bus.req_op == 2'd0) begin
            status_d = ST_ILLEGAL;
            state_d  = RESP;
          end else begin
            op_d    = bus.req_op;
            wdog_d  = '0;
            state_d = RUN;
          end
        end
      RUN:
        if (enter) wdog_d = WW'(1);
        else if (sel_error) begin
          status_d = ST_ERROR;
          state_d  = RESP;
        end else if (sel_done) begin
          status_d = ST_OK;
          state_d  = RESP;
        end else if (wdog_q == WW'(TIMEOUT_CYCLES)) begin
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end else wdog_d = wdog_q + 1'b1;
      RESP:
        if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.req_ready   = state_q == IDLE;
  assign bus.resp_valid  = state_q == RESP;
  assign bus.resp_status = status_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.get_en      = run && op_q == 2'd1;
  assign bus.put_en      = run && op_q == 2'd2;
  assign bus.del_en      = run && op_q == 2'd3;
  assign bus.get_enter   = enter && op_q == 2'd1;
  assign bus.put_enter   = enter && op_q == 2'd2;
  assign bus.del_enter   = enter && op_q == 2'd3;
endmodule
